apb_sfr_bank: RTL and testbench
===============================

# apb_sfr_bank

Parametrised APB4 slave holding a bank of 32-bit special-function registers. It honours per-byte write strobes, decodes several word-aligned registers, inserts a configurable number of wait states through a small access FSM, and flags illegal accesses with PSLVERR. It sits behind the APB interconnect as a peripheral's register file. The register contents are also exported flat to the peripheral core.

## Interface
- NUM_REGS, 4: number of 32-bit registers; legal 1..64.
- ADDR_WIDTH, 8: PADDR width in bits; must satisfy 4*NUM_REGS ≤ 2^ADDR_WIDTH (4*(NUM_REGS+1) when the lock register is compiled in).
- WAIT_STATES, 0: access-phase cycles with PREADY low before completion; legal 0..15.
- RESET_VALUE, 32'h0: reset value of every data register.

- PCLK  in  1  clock, all state updates on rising edge
- PRESETn  in  1  reset, asynchronous, active-low
- PADDR  in  ADDR_WIDTH  byte address; register i at 4*i
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PWRITE  in  1  1 = write, 0 = read
- PWDATA  in  32  write data
- PSTRB  in  4  byte-lane write strobes; PSTRB[k] qualifies PWDATA[8k+7:8k]
- PREADY  out  1  transfer completion
- PRDATA  out  32  read data
- PSLVERR  out  1  error response
- sfr_o  out  32*NUM_REGS  register i on sfr_o[32i+31:32i]

## Operation
- FSM has two states, IDLE and WAIT; wait counter is 4 bits.
  - IDLE: on setup phase (PSEL=1, PENABLE=0), load counter with WAIT_STATES; go to WAIT if WAIT_STATES≠0.
  - WAIT: PREADY=0; counter decrements each cycle; at counter==1, return to IDLE.
  - PSEL=0 while in WAIT (aborted transfer): return to IDLE, counter cleared, no register update.
- PREADY=1 whenever FSM is in IDLE. WAIT_STATES=0 therefore gives zero-wait transfers.
- Completion cycle: PSEL & PENABLE & PREADY.
- Decode: idx = PADDR[ADDR_WIDTH-1:2].
- Error condition: PADDR[1:0]≠0, or idx ≥ NUM_REGS (data registers), or lock violation (see Configuration).
- Write completion without error: for each k with PSTRB[k]=1, reg[idx] byte k ← PWDATA byte k. Other bytes are unchanged. PSTRB=0 is a legal no-op write with OKAY response.
- Write completion with error: no register changes.
- PSTRB is ignored on reads.
- PRDATA: reg[idx] during a read completion without error; otherwise 32'h0. It is combinational from registers and address.
- PSLVERR: 1 only in a completion cycle with the error condition; 0 at all other times.
- sfr_o reflects register contents; the new value is visible the cycle after the write-completion edge.
- Reset (asynchronous, any time including mid-WAIT): FSM→IDLE, counter=0, all registers=RESET_VALUE, lock=0. Output reset values: PREADY=1, PRDATA=0, PSLVERR=0, sfr_o=all RESET_VALUE.

## Timing
- Transfer length is 2+WAIT_STATES cycles: setup, WAIT_STATES wait cycles, completion.
- Register update takes effect at the rising edge ending the completion cycle.
- A back-to-back transfer (new setup immediately after completion) is accepted with no idle cycle.
- A read completing on the cycle after a write to the same register returns the new value.

## Configuration
- Macro: APB_SFR_BANK_LOCK_EN.
- Defined:
  - Extra register at idx NUM_REGS (byte 4*NUM_REGS). Bit 0 is LOCK; bits 31:1 read 0.
  - Writing with PSTRB[0]=1 and PWDATA[0]=1 sets LOCK. LOCK is sticky until reset; writes of 0 are ignored.
  - While LOCK=1, any write to a data register produces PSLVERR=1 and no change. Reads stay legal.
- Undefined: no lock register; idx NUM_REGS is out of range and returns PSLVERR=1.

## Test plan
- Reset, then read all NUM_REGS registers -> each returns RESET_VALUE with PSLVERR=0; PREADY=1 throughout reset.
- Write 32'hAABBCCDD with PSTRB=4'b1111 to reg1, then 32'h11223344 with PSTRB=4'b0101 -> read returns 32'hAA22CC44; sfr_o slice 1 matches.
- WAIT_STATES=3: a write completes with exactly 3 PREADY-low cycles. Drop PSEL after 1 wait cycle on a second transfer -> register unchanged and FSM back in IDLE.
- Access PADDR=4*NUM_REGS (macro off) and PADDR=8'h02 -> PSLVERR=1 on the completion cycle, PRDATA=0, no register change.
- Assert PRESETn low mid-WAIT after a partial sequence -> all outputs at reset values, next transfer behaves normally.
- With APB_SFR_BANK_LOCK_EN: write 1 to lock, then write 32'hFFFFFFFF to reg0 -> PSLVERR=1, reg0 unchanged; lock reads 1; write 0 to lock -> lock stays 1.

Source files
------------

// File: rtl/apb_sfr_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_sfr_bank : APB4 register bank with byte strobes, wait states and PSLVERR.
// Optional sticky lock register: define APB_SFR_BANK_LOCK_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module apb_sfr_bank #(
  parameter int          NUM_REGS    = 4,
  parameter int          ADDR_WIDTH  = 8,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic [ADDR_WIDTH-1:0]    PADDR,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [31:0]              PWDATA,
  input  logic [3:0]               PSTRB,
  output logic                     PREADY,
  output logic [31:0]              PRDATA,
  output logic                     PSLVERR,
  output logic [32*NUM_REGS-1:0]   sfr_o
);

  localparam logic [3:0]  c_wait_init = 4'(WAIT_STATES);
  localparam logic [31:0] c_num_regs  = 32'(NUM_REGS);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        ready_q;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  logic [31:0] w_idx;
  logic        w_misalign;
  logic        w_is_data;
  logic        w_complete;
  logic        w_err;

  assign w_idx      = 32'(PADDR[ADDR_WIDTH-1:2]);
  assign w_misalign = |PADDR[1:0];
  assign w_is_data  = (w_idx < c_num_regs);
  assign w_complete = PSEL & PENABLE & ready_q;

`ifdef APB_SFR_BANK_LOCK_EN
  logic lock_q;
  logic lock_d;
  logic w_is_lock;

  assign w_is_lock = (w_idx == c_num_regs);
  // Reads of data registers stay legal while locked; only writes are refused.
  assign w_err = w_misalign | ~(w_is_data | w_is_lock) | (PWRITE & w_is_data & lock_q);

  always_comb begin
    lock_d = lock_q | (w_complete & PWRITE & ~w_err & w_is_lock & PSTRB[0] & PWDATA[0]);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) lock_q <= 1'b0;
    else          lock_q <= lock_d;
  end
`else
  assign w_err = w_misalign | ~w_is_data;
`endif

  // PREADY is held in ready_q so it tracks the state register exactly.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (PSEL && !PENABLE) begin
            cnt_q <= c_wait_init;
            if (c_wait_init != 4'd0) begin
              state_q <= ST_WAIT;
              ready_q <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (!PSEL) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (w_complete && PWRITE && !w_err && w_is_data) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_idx == 32'(i)) begin
          for (int k = 0; k < 4; k++) begin
            if (PSTRB[k]) regs_d[i][8*k +: 8] = PWDATA[8*k +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    PRDATA = 32'h0;
    if (w_complete && !PWRITE && !w_err) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_idx == 32'(i)) PRDATA = regs_q[i];
      end
`ifdef APB_SFR_BANK_LOCK_EN
      if (w_is_lock) PRDATA = {31'b0, lock_q};
`endif
    end
  end

  assign PREADY  = ready_q;
  assign PSLVERR = w_complete & w_err;

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_sfr
      assign sfr_o[32*i +: 32] = regs_q[i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_apb_sfr_bank.sv
`default_nettype none
// Self-checking bench for apb_sfr_bank: vector table plus hand-written
// sequences for abort, back-to-back, mid-wait reset and (optionally) lock.
module tb_apb_sfr_bank;
  localparam int          NUM_REGS    = 4;
  localparam int          ADDR_WIDTH  = 8;
  localparam int          WAIT_STATES = 3;
  localparam logic [31:0] RV          = 32'hDEADBEEF;

  logic                    PCLK = 1'b0;
  logic                    PRESETn;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic                    PSEL, PENABLE, PWRITE;
  logic [31:0]             PWDATA;
  logic [3:0]              PSTRB;
  logic                    PREADY;
  logic [31:0]             PRDATA;
  logic                    PSLVERR;
  logic [32*NUM_REGS-1:0]  sfr_o;

  apb_sfr_bank #(
    .NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH),
    .WAIT_STATES(WAIT_STATES), .RESET_VALUE(RV)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR), .sfr_o(sfr_o)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb_q[$];
  logic [31:0] mdl [NUM_REGS];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic add(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                     input logic [3:0] st, input logic [31:0] erd, input logic eerr);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wd; v.strb = st; v.erd = erd; v.eerr = eerr;
    vecs.push_back(v);
  endtask

  function automatic logic [127:0] sfr_exp();
    logic [127:0] r;
    for (int i = 0; i < NUM_REGS; i++) r[32*i +: 32] = mdl[i];
    return r;
  endfunction

  // One full APB transfer; expectation queued at setup, compared at completion.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] erd, input logic eerr);
    exp_t e;
    int   waits;
    bit   done;
    e.rdata = erd; e.err = eerr;
    sb_q.push_back(e);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd; PSTRB = st;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0; done = 1'b0;
    while (!done && waits <= 40) begin
      @(negedge PCLK);
      if (PREADY) done = 1'b1;
      else        waits++;
    end
    e = sb_q.pop_front();
    if (!done) begin
      n_checks++;
      $display("FAIL timeout @%h: PREADY low %0d cycles, required %0d", addr, waits, WAIT_STATES);
    end else begin
      check($sformatf("wait_cnt@%h", addr), 128'(waits), 128'(WAIT_STATES));
      check($sformatf("prdata@%h", addr), 128'(PRDATA), 128'(e.rdata));
      check($sformatf("pslverr@%h", addr), 128'(PSLVERR), 128'(e.err));
    end
  endtask

  task automatic idle();
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pready"},  128'(PREADY),  128'(1'b1));
    check({tag, "_prdata"},  128'(PRDATA),  128'(32'h0));
    check({tag, "_pslverr"}, 128'(PSLVERR), 128'(1'b0));
    check({tag, "_sfr"},     sfr_o,         {4{RV}});
  endtask

  initial begin
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0;

    for (int i = 0; i < NUM_REGS; i++) add(1'b0, 8'(4*i), 32'h0, 4'h0, RV, 1'b0);
    add(1'b1, 8'h04, 32'hAABBCCDD, 4'b1111, 32'h0, 1'b0);
    add(1'b1, 8'h04, 32'h11223344, 4'b0101, 32'h0, 1'b0);
    add(1'b0, 8'h04, 32'h0,        4'b0000, 32'hAA22CC44, 1'b0);
    add(1'b1, 8'h08, 32'h12345678, 4'b0000, 32'h0, 1'b0);
    add(1'b0, 8'h08, 32'h0,        4'b1111, RV, 1'b0);
    add(1'b1, 8'h02, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1);
    add(1'b0, 8'h02, 32'h0,        4'b0000, 32'h0, 1'b1);
    add(1'b1, 8'h0C, 32'hCAFEF00D, 4'b1100, 32'h0, 1'b0);
    add(1'b0, 8'h0C, 32'h0,        4'b0000, 32'hCAFEBEEF, 1'b0);
    add(1'b1, 8'h0D, 32'h00000000, 4'b1111, 32'h0, 1'b1);
    add(1'b0, 8'h0C, 32'h0,        4'b0000, 32'hCAFEBEEF, 1'b0);
`ifdef APB_SFR_BANK_LOCK_EN
    add(1'b1, 8'h10, 32'h00000000, 4'b1111, 32'h0, 1'b0);
    add(1'b0, 8'h10, 32'h0,        4'b0000, 32'h0, 1'b0);
`else
    add(1'b1, 8'h10, 32'h00000000, 4'b1111, 32'h0, 1'b1);
    add(1'b0, 8'h10, 32'h0,        4'b0000, 32'h0, 1'b1);
`endif
    add(1'b0, 8'h14, 32'h0,        4'b0000, 32'h0, 1'b1);
    add(1'b0, 8'hFC, 32'h0,        4'b0000, 32'h0, 1'b1);

    repeat (2) @(negedge PCLK);
    check_reset_outputs("reset");
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = RV;

    foreach (vecs[n]) begin
      xfer(vecs[n].wr, vecs[n].addr, vecs[n].wdata, vecs[n].strb, vecs[n].erd, vecs[n].eerr);
      idle();
      if (vecs[n].wr && !vecs[n].eerr && vecs[n].addr < 8'(4*NUM_REGS)) begin
        for (int k = 0; k < 4; k++)
          if (vecs[n].strb[k]) mdl[vecs[n].addr[3:2]][8*k +: 8] = vecs[n].wdata[8*k +: 8];
      end
      check($sformatf("sfr_o[%0d]", n), sfr_o, sfr_exp());
    end

    // Back-to-back: read completes right after write to the same register.
    xfer(1'b1, 8'h00, 32'h01020304, 4'hF, 32'h0, 1'b0);
    xfer(1'b0, 8'h00, 32'h0, 4'h0, 32'h01020304, 1'b0);
    idle();
    mdl[0] = 32'h01020304;
    check("b2b_sfr", sfr_o, sfr_exp());

    // Aborted transfer: PSEL dropped after one wait cycle.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h04; PWDATA = 32'h0; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    check("abort_wait_pready", 128'(PREADY), 128'(1'b0));
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    check("abort_idle_pready", 128'(PREADY), 128'(1'b1));
    check("abort_sfr", sfr_o, sfr_exp());
    xfer(1'b0, 8'h04, 32'h0, 4'h0, 32'hAA22CC44, 1'b0);
    idle();

`ifdef APB_SFR_BANK_LOCK_EN
    xfer(1'b1, 8'h10, 32'h00000001, 4'h1, 32'h0, 1'b0);
    xfer(1'b1, 8'h00, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    xfer(1'b0, 8'h00, 32'h0, 4'h0, 32'h01020304, 1'b0);
    xfer(1'b0, 8'h10, 32'h0, 4'h0, 32'h00000001, 1'b0);
    xfer(1'b1, 8'h10, 32'h00000000, 4'hF, 32'h0, 1'b0);
    xfer(1'b0, 8'h10, 32'h0, 4'h0, 32'h00000001, 1'b0);
    idle();
    check("lock_sfr", sfr_o, sfr_exp());
`endif

    // Asynchronous reset in the middle of a wait sequence.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h08; PWDATA = 32'h0BADF00D; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    check("midwait_pready", 128'(PREADY), 128'(1'b0));
    #1;
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    #2;
    check_reset_outputs("midreset");
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = RV;

    xfer(1'b1, 8'h08, 32'h13579BDF, 4'hF, 32'h0, 1'b0);
    xfer(1'b0, 8'h08, 32'h0, 4'h0, 32'h13579BDF, 1'b0);
    xfer(1'b1, 8'h00, 32'h2468ACE0, 4'hF, 32'h0, 1'b0);
    xfer(1'b0, 8'h00, 32'h0, 4'h0, 32'h2468ACE0, 1'b0);
    idle();
    mdl[2] = 32'h13579BDF;
    mdl[0] = 32'h2468ACE0;
    check("post_reset_sfr", sfr_o, sfr_exp());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end
endmodule
`default_nettype wire
